// File: rtl/deser_queue_top.sv
// ---------------------------------------------------------------------------
// deser_queue_top
//
// Serial-to-parallel receive path feeding a small byte queue. One serial bit
// is captured per rising edge of write_in. Each completed byte is pushed into
// a circular queue that a downstream consumer drains with dequeue_in.
//
// Parameters:
//   DEPTH        queue entries; power of two, 1..8, so the count fits len_out
//
// Ports:
//   clock        system clock, all logic on the rising edge
//   reset        synchronous active-low reset
//   data_in      serial data bit, sampled when a write_in rise is seen
//   write_in     bit strobe; only the 0->1 transition is significant
//   status_out   1 while the deserializer accepts bits (RX), 0 while pushing
//   dequeue_in   level-sensitive pop request, one entry per cycle while high
//   data_out     last byte popped from the queue
//   len_out      current number of queue entries, 0..DEPTH
//
// Build option:
//   DESER_MSB_FIRST_EN  when defined the first received bit lands in bit 7;
//                       otherwise (default) the first bit lands in bit 0.
// ---------------------------------------------------------------------------
module deser_queue_top #(
  parameter int unsigned DEPTH = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       data_in,
  input  logic       write_in,
  output logic       status_out,
  input  logic       dequeue_in,
  output logic [7:0] data_out,
  output logic [3:0] len_out
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned LEN_W  = 4;
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    RX   = 1'b0,
    PUSH = 1'b1
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic                write_q;
  logic [CNT_W-1:0]    bit_cnt_q;
  logic [CNT_W-1:0]    bit_cnt_d;
  logic [DATA_W-1:0]   shreg_q;
  logic [DATA_W-1:0]   shreg_d;
  logic [DATA_W-1:0]   shreg_shift_c;
  logic [PTR_W-1:0]    wr_ptr_q;
  logic [PTR_W-1:0]    rd_ptr_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                rise_c;
  logic                full_c;
  logic                push_c;
  logic                pop_c;

  // Circular pointer advance, wrapping modulo DEPTH.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(DEPTH - 1)) begin
      next_ptr = '0;
    end else begin
      next_ptr = ptr + PTR_W'(1);
    end
  endfunction

  // Strobe rise: current high, previous registered sample low.
  assign rise_c = write_in & ~write_q;

  // Full and pop decisions both use the pre-edge count.
  assign full_c = (len_out == LEN_W'(DEPTH));
  assign pop_c  = dequeue_in & (len_out != '0);

  // Bit order selection for the assembly register.
`ifdef DESER_MSB_FIRST_EN
  assign shreg_shift_c = {shreg_q[DATA_W-2:0], data_in};
`else
  assign shreg_shift_c = {data_in, shreg_q[DATA_W-1:1]};
`endif

  // Deserializer next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    push_c    = 1'b0;
    case (state_q)
      RX: begin
        if (rise_c) begin
          shreg_d = shreg_shift_c;
          if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
            bit_cnt_d = '0;
            state_d   = PUSH;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      PUSH: begin
        // Strobe rises here are deliberately dropped.
        if (!full_c) begin
          push_c  = 1'b1;
          state_d = RX;
        end
      end
      default: begin
        state_d = RX;
      end
    endcase
  end

  // Deserializer state, edge register and registered ready decode.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= RX;
      write_q    <= 1'b0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      status_out <= 1'b0;
    end else begin
      state_q    <= state_d;
      write_q    <= write_in;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      status_out <= (state_d == RX);
    end
  end

  // Queue storage; contents are invalidated by pointer reset, not cleared.
  always_ff @(posedge clock) begin
    if (reset && push_c) begin
      mem[wr_ptr_q] <= shreg_q;
    end
  end

  // Queue pointers, occupancy and pop data.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      len_out  <= '0;
      data_out <= '0;
    end else begin
      if (push_c) begin
        wr_ptr_q <= next_ptr(wr_ptr_q);
      end
      if (pop_c) begin
        data_out <= mem[rd_ptr_q];
        rd_ptr_q <= next_ptr(rd_ptr_q);
      end
      case ({push_c, pop_c})
        2'b10:   len_out <= len_out + LEN_W'(1);
        2'b01:   len_out <= len_out - LEN_W'(1);
        default: len_out <= len_out;
      endcase
    end
  end

endmodule

// File: tb/tb_deser_queue_top.sv
// ---------------------------------------------------------------------------
// tb_deser_queue_top
//
// Self-checking bench for deser_queue_top. A cycle-level reference model
// (bit position arithmetic plus a byte queue) predicts status_out, len_out
// and data_out after every clock; directed scenarios add explicit checks.
// ---------------------------------------------------------------------------
module tb_deser_queue_top;

  localparam int unsigned DEPTH = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       data_in = 1'b0;
  logic       write_in = 1'b0;
  logic       dequeue_in = 1'b0;
  logic       status_out;
  logic [7:0] data_out;
  logic [3:0] len_out;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  bit         m_receiving = 1'b1;
  int         m_nbits = 0;
  logic [7:0] m_acc = 8'h00;
  logic [7:0] m_data = 8'h00;
  bit         m_status = 1'b0;
  bit         m_prev_w = 1'b0;
  logic [7:0] m_q[$];

  deser_queue_top #(.DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .data_in    (data_in),
    .write_in   (write_in),
    .status_out (status_out),
    .dequeue_in (dequeue_in),
    .data_out   (data_out),
    .len_out    (len_out)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs about to be applied.
  task automatic model_step(input bit r, input bit d, input bit w, input bit deq);
    int size_pre;
    bit full_pre;
    bit rise;
    if (!r) begin
      m_receiving = 1'b1;
      m_nbits     = 0;
      m_acc       = 8'h00;
      m_data      = 8'h00;
      m_status    = 1'b0;
      m_prev_w    = 1'b0;
      m_q.delete();
    end else begin
      rise     = w && !m_prev_w;
      m_prev_w = w;
      size_pre = m_q.size();
      full_pre = (size_pre == int'(DEPTH));
      if (deq && size_pre > 0) m_data = m_q.pop_front();
      if (!m_receiving) begin
        if (!full_pre) begin
          m_q.push_back(m_acc);
          m_acc       = 8'h00;
          m_receiving = 1'b1;
        end
      end else if (rise) begin
`ifdef DESER_MSB_FIRST_EN
        m_acc[7 - m_nbits] = d;
`else
        m_acc[m_nbits] = d;
`endif
        m_nbits++;
        if (m_nbits == 8) begin
          m_nbits     = 0;
          m_receiving = 1'b0;
        end
      end
      m_status = m_receiving;
    end
  endtask

  // One clock: apply inputs at the falling edge, check at the next falling edge.
  task automatic step(input bit r, input bit d, input bit w, input bit deq);
    reset      = r;
    data_in    = d;
    write_in   = w;
    dequeue_in = deq;
    model_step(r, d, w, deq);
    @(negedge clock);
    check_eq("status", {7'd0, status_out}, {7'd0, m_status});
    check_eq("len", {4'd0, len_out}, 8'(m_q.size()));
    check_eq("data", data_out, m_data);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_bit(input bit b, input int hi, input int lo);
    for (int i = 0; i < hi; i++) step(1'b1, b, 1'b1, 1'b0);
    for (int i = 0; i < lo; i++) step(1'b1, b, 1'b0, 1'b0);
  endtask

  // Send 8 bits in transmission order s[7] first.
  task automatic send_seq(input logic [7:0] s, input int hi, input int lo);
    for (int i = 0; i < 8; i++) send_bit(s[7 - i], hi, lo);
  endtask

  // Send a byte in the order that reassembles it to the same value.
  task automatic send_byte(input logic [7:0] x);
    for (int i = 0; i < 8; i++) begin
`ifdef DESER_MSB_FIRST_EN
      send_bit(x[7 - i], 2, 2);
`else
      send_bit(x[i], 2, 2);
`endif
    end
  endtask

  task automatic wait_ready();
    int budget;
    budget = 0;
    while (!status_out && budget < 100) begin
      idle(1);
      budget++;
    end
    check_eq("ready", {7'd0, status_out}, 8'h01);
  endtask

  initial begin
    logic [7:0] exp80;
    bit r;
    bit w;
    bit deq;
    int pop_div;

    @(negedge clock);

    // Reset held for three cycles, then released.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      check_eq("rst_status", {7'd0, status_out}, 8'h00);
      check_eq("rst_len", {4'd0, len_out}, 8'h00);
      check_eq("rst_data", data_out, 8'h00);
    end
    idle(1);
    check_eq("rel_status", {7'd0, status_out}, 8'h01);

    // Palindrome byte with slow strobes.
    send_seq(8'b1001_1001, 10, 10);
    idle(2);
    check_eq("b99_len", {4'd0, len_out}, 8'h01);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("b99_data", data_out, 8'h99);
    check_eq("b99_len0", {4'd0, len_out}, 8'h00);

    // Long strobe on one bit still yields one bit.
    wait_ready();
    for (int i = 0; i < 8; i++) begin
`ifdef DESER_MSB_FIRST_EN
      send_bit(8'hA5 >> (7 - i), (i == 3) ? 50 : 2, 2);
`else
      send_bit(8'hA5 >> i, (i == 3) ? 50 : 2, 2);
`endif
    end
    idle(2);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("long_data", data_out, 8'hA5);

    // Pop on empty leaves data and count alone.
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("empty_data", data_out, 8'hA5);
    check_eq("empty_len", {4'd0, len_out}, 8'h00);

    // Single leading one: 0x01 LSB-first, 0x80 MSB-first.
`ifdef DESER_MSB_FIRST_EN
    exp80 = 8'h80;
`else
    exp80 = 8'h01;
`endif
    wait_ready();
    send_seq(8'b1000_0000, 2, 2);
    idle(2);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("seq80_data", data_out, exp80);

    // Fill the queue, then a ninth byte stalls until a pop.
    for (int b = 1; b <= 8; b++) begin
      wait_ready();
      send_byte(8'(b));
    end
    idle(2);
    check_eq("fill_len", {4'd0, len_out}, 8'h08);
    wait_ready();
    send_byte(8'h09);
    idle(3);
    check_eq("stall_status", {7'd0, status_out}, 8'h00);
    check_eq("stall_len", {4'd0, len_out}, 8'h08);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("stall_pop", data_out, 8'h01);
    check_eq("stall_len7", {4'd0, len_out}, 8'h07);
    idle(1);
    check_eq("stall_len8", {4'd0, len_out}, 8'h08);
    check_eq("stall_ready", {7'd0, status_out}, 8'h01);

    // Drain to three, then pop coincident with a push.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("drain_len", {4'd0, len_out}, 8'h03);
    for (int i = 0; i < 7; i++) send_bit(i[0], 2, 2);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check_eq("pp_status", {7'd0, status_out}, 8'h00);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check_eq("pp_len", {4'd0, len_out}, 8'h03);
    idle(2);

    // Randomized traffic with occasional resets and varying pop rates.
    w = 1'b0;
    for (int c = 0; c < 6000; c++) begin
      pop_div = (c < 3000) ? 48 : 4;
      r   = ($urandom_range(0, 999) != 0);
      if ($urandom_range(0, 2) == 0) w = ~w;
      deq = ($urandom_range(0, pop_div - 1) == 0);
      step(r, 1'($urandom), w, deq);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
